// File: rtl/queue_2x124_ctrl.sv
// Ready/valid FIFO controller driving an external 2-entry two-port RAM.
// Tracks enqueue/dequeue pointers plus a maybe_full bit to tell full from empty.
module queue_2x124_ctrl #(
  parameter int unsigned WIDTH  = 124,
  parameter int unsigned ADDR_W = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [WIDTH-1:0]  enq_bits,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [WIDTH-1:0]  deq_bits,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] ram_W0_addr,
  output logic              ram_W0_en,
  output logic              ram_W0_clk,
  output logic [WIDTH-1:0]  ram_W0_data,
  output logic [ADDR_W-1:0] ram_R0_addr,
  output logic              ram_R0_en,
  output logic              ram_R0_clk,
  input  logic [WIDTH-1:0]  ram_R0_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [ADDR_W-1:0] enq_ptr_q, enq_ptr_d;
  logic [ADDR_W-1:0] deq_ptr_q, deq_ptr_d;
  logic              maybe_full_q, maybe_full_d;
  logic              ptr_match, empty, full, do_enq, do_deq;
  logic [ADDR_W-1:0] ptr_diff;

  // Both RAM ports run on the controller clock.
  assign ram_W0_clk = clock;
  assign ram_R0_clk = clock;

  // Pointer registers; reset empties the queue immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enq_ptr_q    <= '0;
      deq_ptr_q    <= '0;
      maybe_full_q <= 1'b0;
    end else begin
      enq_ptr_q    <= enq_ptr_d;
      deq_ptr_q    <= deq_ptr_d;
      maybe_full_q <= maybe_full_d;
    end
  end

  // Handshake, RAM port drive and next-state pointer logic.
  always_comb begin
    ptr_match    = (enq_ptr_q == deq_ptr_q);
    empty        = ptr_match & ~maybe_full_q;
    full         = ptr_match & maybe_full_q;
    enq_ready    = ~full;
    deq_valid    = ~empty;
    do_enq       = enq_valid & enq_ready;
    do_deq       = deq_valid & deq_ready;

    ram_W0_en    = do_enq;
    ram_W0_addr  = enq_ptr_q;
    ram_W0_data  = enq_bits;
    ram_R0_en    = ~empty;
    ram_R0_addr  = deq_ptr_q;
    deq_bits     = ram_R0_data;

    enq_ptr_d    = enq_ptr_q;
    deq_ptr_d    = deq_ptr_q;
    maybe_full_d = maybe_full_q;
    // Power-of-two depth, so pointer wrap is plain overflow.
    if (do_enq) enq_ptr_d = enq_ptr_q + ADDR_W'(1);
    if (do_deq) deq_ptr_d = deq_ptr_q + ADDR_W'(1);
    if (do_enq != do_deq) maybe_full_d = do_enq;

    ptr_diff     = enq_ptr_q - deq_ptr_q;
    count        = full ? CNT_W'(DEPTH) : CNT_W'(ptr_diff);
  end

endmodule

// File: tb/tb_queue_2x124_ctrl.sv
// Randomised and directed bench for queue_2x124_ctrl with a behavioural RAM and a
// queue-based reference model; stimulus and output checking run in separate processes.
module tb_queue_2x124_ctrl;

  localparam int unsigned W     = 124;
  localparam int unsigned DEPTH = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          enq_valid, enq_ready, deq_valid, deq_ready;
  logic [W-1:0]  enq_bits, deq_bits;
  logic [1:0]    count;
  logic [0:0]    ram_W0_addr, ram_R0_addr;
  logic          ram_W0_en, ram_W0_clk, ram_R0_en, ram_R0_clk;
  logic [W-1:0]  ram_W0_data, ram_R0_data;

  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  sb [$];
  int            occ = 0;
  int            checks = 0;
  int            errors = 0;

  queue_2x124_ctrl dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_bits(enq_bits),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_bits(deq_bits),
    .count(count),
    .ram_W0_addr(ram_W0_addr), .ram_W0_en(ram_W0_en), .ram_W0_clk(ram_W0_clk),
    .ram_W0_data(ram_W0_data),
    .ram_R0_addr(ram_R0_addr), .ram_R0_en(ram_R0_en), .ram_R0_clk(ram_R0_clk),
    .ram_R0_data(ram_R0_data)
  );

  always #5 clock = ~clock;

  // External RAM: synchronous write, combinational read.
  always @(posedge ram_W0_clk) if (ram_W0_en) mem[ram_W0_addr] <= ram_W0_data;
  assign ram_R0_data = ram_R0_en ? mem[ram_R0_addr] : '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy and expected order derived from handshake rules.
  always @(negedge clock) begin
    if (!reset) begin
      bit efire, dfire;
      check("count", 128'(count), 128'(occ));
      check("enq_ready", 128'(enq_ready), 128'(occ < DEPTH));
      check("deq_valid", 128'(deq_valid), 128'(occ > 0));
      efire = enq_valid && (occ < DEPTH);
      dfire = deq_ready && (occ > 0);
      check("ram_W0_en", 128'(ram_W0_en), 128'(efire));
      if (ram_W0_en && ram_R0_en)
        check("addr_collision", 128'(ram_W0_addr != ram_R0_addr), 128'(1));
      if (efire) sb.push_back(enq_bits);
      occ = occ + int'(efire) - int'(dfire);
    end
  end

  // Output monitor: every accepted dequeue must match the oldest expected item.
  always @(negedge clock) begin
    if (!reset && deq_valid && deq_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL deq_unexpected actual=%0h required=none at %0t", deq_bits, $time);
      end else begin
        check("deq_bits", 128'(deq_bits), 128'(sb.pop_front()));
      end
    end
  end

  // Drive for one cycle: inputs change 1ns after the edge, held through the next edge.
  task automatic drive(input logic ev, input logic [W-1:0] b, input logic dr);
    enq_valid = ev;
    enq_bits  = b;
    deq_ready = dr;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_enq_ready", 128'(enq_ready), 128'(1));
    check("rst_deq_valid", 128'(deq_valid), 128'(0));
    check("rst_count", 128'(count), 128'(0));
    check("rst_w0_en", 128'(ram_W0_en), 128'(0));
    check("rst_r0_en", 128'(ram_R0_en), 128'(0));
    sb.delete();
    occ = 0;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int idx, cyc;
    logic ev, dr, fire;
    reset = 1'b0;
    enq_valid = 1'b0;
    enq_bits = '0;
    deq_ready = 1'b0;
    @(posedge clock);
    #1;
    pulse_reset();

    // Single item
    drive(1'b1, W'(124'hA5), 1'b0);
    check("single_count", 128'(count), 128'(1));
    check("single_bits", 128'(deq_bits), 128'(124'hA5));
    drive(1'b0, '0, 1'b1);
    check("single_drained", 128'(count), 128'(0));

    // Fill, blocked third enqueue, drain
    drive(1'b1, W'(124'h1), 1'b0);
    drive(1'b1, W'(124'h2), 1'b0);
    check("fill_count", 128'(count), 128'(2));
    check("fill_ready", 128'(enq_ready), 128'(0));
    enq_valid = 1'b1;
    enq_bits  = W'(124'h3);
    #1;
    check("full_no_write", 128'(ram_W0_en), 128'(0));
    drive(1'b1, W'(124'h3), 1'b0);
    drive(1'b1, W'(124'h3), 1'b1);
    drive(1'b1, W'(124'h3), 1'b1);
    check("after_fill_head", 128'(deq_bits), 128'(124'h3));
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);

    // Concurrent enq+deq at count 1
    drive(1'b1, W'(124'h10), 1'b0);
    drive(1'b1, W'(124'h11), 1'b1);
    check("conc_count", 128'(count), 128'(1));
    check("conc_head", 128'(deq_bits), 128'(124'h11));
    drive(1'b0, '0, 1'b1);

    // Wrap: stream 0x20..0x27 with random stalls
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 400) begin
      ev = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      fire = ev & enq_ready;
      drive(ev, W'(124'h20 + idx), dr);
      if (fire) idx++;
      cyc++;
    end
    check("wrap_all_sent", 128'(idx), 128'(8));
    cyc = 0;
    while (occ > 0 && cyc < 20) begin
      drive(1'b0, '0, 1'b1);
      cyc++;
    end
    check("wrap_drained", 128'(count), 128'(0));

    // Random traffic with random wide payloads
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)),
            {$urandom(), $urandom(), $urandom(), 28'($urandom())},
            1'($urandom_range(0, 3) != 0));
    end
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);

    // Reset mid-operation with a full queue
    drive(1'b1, W'(124'h40), 1'b0);
    drive(1'b1, W'(124'h41), 1'b0);
    check("pre_reset_count", 128'(count), 128'(2));
    pulse_reset();
    drive(1'b1, W'(124'h30), 1'b0);
    check("post_reset_count", 128'(count), 128'(1));
    check("post_reset_head", 128'(deq_bits), 128'(124'h30));
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);
    check("sb_empty", 128'(sb.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
